// File: rtl/audio_pll_lock_sequencer_if.sv
// Audio PLL lock sequencer handshake bundle.
// master: sequencer side (drives pll_rst/audio_rst/ready/state/counters); slave: PLL/system side.
interface audio_pll_lock_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             relock_req;
  logic             pll_rst;
  logic             audio_rst;
  logic             ready;
  logic [1:0]       state;
  logic [CNT_W-1:0] lock_loss_cnt;
  logic [CNT_W-1:0] timeout_cnt;

  modport master (
    input  pll_locked, relock_req,
    output pll_rst, audio_rst, ready, state,
    output lock_loss_cnt, timeout_cnt
  );

  modport slave (
    output pll_locked, relock_req,
    input  pll_rst, audio_rst, ready, state,
    input  lock_loss_cnt, timeout_cnt
  );
endinterface

// File: rtl/audio_pll_lock_sequencer.sv
// Audio PLL reset/lock supervisor on refclk; releases audio_rst only after filtered lock.
// Ports: refclk, rst (async high), bus (master). Macro AUDIO_PLL_SEQ_COUNTERS_EN adds event counters.
module audio_pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 8
) (
  input  logic                        refclk,
  input  logic                        rst,
  audio_pll_lock_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_WAIT   = 2'd1,
    S_STABLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  localparam int M1 =
    (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int M2 =
    (M1 > PLL_RST_CYCLES) ? M1 : PLL_RST_CYCLES;
  localparam int TMR_W = $clog2(M2);

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] ST_LAST  = TMR_W'(STABLE_CYCLES - 1);

  state_t           state_q, state_n;
  logic [TMR_W-1:0] tmr_q, tmr_n;
  logic [1:0]       sync_q;
  logic             lk;
  logic             relock;
  logic             clr;
  logic             pll_rst_q, audio_rst_q, ready_q;

  assign lk     = sync_q[1];
  assign relock = bus.relock_req;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], bus.pll_locked};
  end

  always_comb begin
    state_n = state_q;
    clr     = 1'b0;
    if (relock) begin
      state_n = S_RESET;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        S_RESET:  if (tmr_q == RST_LAST) state_n = S_WAIT;
        S_WAIT: begin
          if (lk)                   state_n = S_STABLE;
          else if (tmr_q == TO_LAST) state_n = S_RESET;
        end
        S_STABLE: begin
          if (!lk)                   state_n = S_WAIT;
          else if (tmr_q == ST_LAST) state_n = S_RUN;
        end
        S_RUN:    if (!lk) state_n = S_RESET;
        default:  state_n = S_RESET;
      endcase
    end
    if (state_n != state_q) clr = 1'b1;
    // The timer is meaningless in RUN; hold it so it never wraps there.
    if (clr || state_n == S_RUN) tmr_n = '0;
    else                         tmr_n = tmr_q + 1'b1;
  end

  // Outputs are registered from the next state so they move with state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET;
      tmr_q       <= '0;
      pll_rst_q   <= 1'b1;
      audio_rst_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_n;
      tmr_q       <= tmr_n;
      pll_rst_q   <= (state_n == S_RESET);
      audio_rst_q <= (state_n != S_RUN);
      ready_q     <= (state_n == S_RUN);
    end
  end

  assign bus.state     = state_q;
  assign bus.pll_rst   = pll_rst_q;
  assign bus.audio_rst = audio_rst_q;
  assign bus.ready     = ready_q;

`ifdef AUDIO_PLL_SEQ_COUNTERS_EN
  logic [CNT_W-1:0] ll_q, to_q;
  logic             ll_inc, to_inc;

  // relock_req suppresses both increments in its cycle.
  assign to_inc = !relock && state_q == S_WAIT && !lk && tmr_q == TO_LAST;
  assign ll_inc = !relock && state_q == S_RUN && !lk;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      ll_q <= '0;
      to_q <= '0;
    end else begin
      if (ll_inc && ll_q != '1) ll_q <= ll_q + 1'b1;
      if (to_inc && to_q != '1) to_q <= to_q + 1'b1;
    end
  end

  assign bus.lock_loss_cnt = ll_q;
  assign bus.timeout_cnt   = to_q;
`else
  assign bus.lock_loss_cnt = {CNT_W{1'b0}};
  assign bus.timeout_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/audio_pll_lock_sequencer.md
# audio_pll_lock_sequencer

Reset and lock supervisor for the audio PLL in the audio playback subsystem. It drives the PLL's active-high reset, waits for a filtered lock indication, and only then releases reset to the 12.288 MHz audio domain. On lock loss, lock timeout or a software relock request, it re-runs the sequence. The block runs on the 50 MHz reference clock, which is free-running and independent of the PLL output.

## Interface
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥2).
- `LOCK_TIMEOUT`, 65536: max cycles in WAIT_LOCK before retry (≥4).
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before RUN (≥2).
- `CNT_W`, 8: width of event counters.
- `refclk` in 1: 50 MHz reference clock, sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `pll_locked` in 1: PLL `locked`, asynchronous to `refclk`.
- `relock_req` in 1: single-cycle pulse, forces a new sequence.
- `pll_rst` out 1: reset to the PLL.
- `audio_rst` out 1: active-high reset for audio-domain logic. The consumer must synchronize it into its own clock.
- `ready` out 1: high only in RUN.
- `state` out 2: 0 RESET, 1 WAIT_LOCK, 2 STABLE, 3 RUN.
- `lock_loss_cnt` out CNT_W: RUN→RESET transitions caused by lock drop. Saturating.
- `timeout_cnt` out CNT_W: WAIT_LOCK timeouts. Saturating.

## Operation
- `pll_locked` passes through a 2-flop synchronizer. `lk` denotes the synchronized value.
- A single timer `tmr` is cleared on every state change.
- **RESET**: `pll_rst`=1, `audio_rst`=1.
  - When `tmr`==PLL_RST_CYCLES-1, go to WAIT_LOCK.
- **WAIT_LOCK**: `pll_rst`=0, `audio_rst`=1.
  - If `lk`=1, go to STABLE.
  - Else if `tmr`==LOCK_TIMEOUT-1, go to RESET and increment `timeout_cnt`.
- **STABLE**: `pll_rst`=0, `audio_rst`=1.
  - If `lk`=0, go to WAIT_LOCK with the timer cleared.
  - Else if `tmr`==STABLE_CYCLES-1, go to RUN.
- **RUN**: `pll_rst`=0, `audio_rst`=0, `ready`=1.
  - If `lk`=0, go to RESET and increment `lock_loss_cnt`.
- **relock_req** in any state:
  - Go to RESET with the timer cleared.
  - It has priority over every other transition, and no counter increments that cycle.
  - In RESET it restarts the reset interval.
- Counters saturate at 2^CNT_W-1 and never wrap.
- All outputs are registered and change on the same `refclk` edge as `state`. There are no combinational paths from inputs to outputs.
- **Reset values**: `state`=RESET, `pll_rst`=1, `audio_rst`=1, `ready`=0, both counters 0, `tmr`=0, synchronizer flops 0.
  - Asserting `rst` mid-sequence returns all of these values immediately (asynchronous assertion).
  - Deassertion is sampled on `refclk`. The first RESET interval counts from the first edge after deassertion.

## Timing
- `pll_rst` high for exactly PLL_RST_CYCLES cycles per attempt.
- `pll_locked` rise → STABLE entry: 3 edges (2 synchronizer + 1 state).
- Lock held continuously → `audio_rst` falls STABLE_CYCLES cycles after STABLE entry.
- Lock drop in RUN → `audio_rst` and `pll_rst` high 3 edges after the `pll_locked` fall.
- Glitches shorter than one `refclk` cycle may be missed. Glitches that reach `lk` during STABLE restart the stability window.
- `relock_req` → `state`=RESET and `pll_rst`=1 on the next edge.

## Configuration
- **`AUDIO_PLL_SEQ_COUNTERS_EN` defined**: `lock_loss_cnt` and `timeout_cnt` are implemented as specified.
- **Undefined**:
  - Both counter outputs are tied to 0 and no counter flops exist.
  - The state machine and all other outputs are unchanged.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, CNT_W=4, macro defined.
- **Nominal bring-up**: release `rst`, raise `pll_locked` at cycle 10 → `pll_rst` high cycles 0–3; STABLE at cycle 13; `audio_rst`=0 and `ready`=1 at cycle 21; counters 0.
- **Timeout**: hold `pll_locked`=0 → after 4 RESET + 32 WAIT_LOCK cycles, `pll_rst` reasserts and `timeout_cnt`=1; after 16 attempts `timeout_cnt` stays at 15.
- **Unstable lock**: `pll_locked` high 5 cycles, low 2, then high → STABLE aborts to WAIT_LOCK; RUN reached 8 cycles after the second STABLE entry.
- **Lock loss in RUN**: drop `pll_locked` → 3 edges later `audio_rst`=1, `pll_rst`=1, `lock_loss_cnt`=1; re-raising lock returns to RUN.
- **relock_req in the same cycle as a WAIT_LOCK timeout** → RESET entered, `timeout_cnt` unchanged. **relock_req in RUN** → RESET, `lock_loss_cnt` unchanged.
- **Async `rst` pulse mid-STABLE** → all outputs at reset values before the next `refclk` edge. **Macro undefined**: counters read 0 throughout.
